// File: rtl/branch_predict_ctrl_pkg.sv
// branch_predict_ctrl_pkg: shared counter encodings, FSM states and PC-to-index rule
package branch_predict_ctrl_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_t;
  typedef enum logic {INIT, RUN} state_t;
  localparam int IDX_LSB = 2;
  function automatic logic [31-IDX_LSB:0] pc_word(input logic [31:0] pc);
    return pc[31:IDX_LSB];
  endfunction
endpackage

// File: rtl/branch_predict_ctrl_if.sv
// branch_predict_ctrl_if: ID/EX pipeline inputs and redirect outputs of the branch predictor
interface branch_predict_ctrl_if;
  logic        stall;
  logic        id_valid;
  logic        id_is_branch;
  logic [31:0] id_pc;
  logic [31:0] id_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        id_pred_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;
  modport master (
    output stall, id_valid, id_is_branch, id_pc, id_target,
    output ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken, ex_pc, ex_target,
    input  id_pred_taken, redirect, redirect_pc, flush_if, flush_id
  );
  modport slave (
    input  stall, id_valid, id_is_branch, id_pc, id_target,
    input  ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken, ex_pc, ex_target,
    output id_pred_taken, redirect, redirect_pc, flush_if, flush_id
  );
endinterface

// File: rtl/branch_predict_ctrl_bht_table.sv
// bht_table: 2-bit saturating counter table, combinational read, one synchronous write
module bht_table
  import branch_predict_ctrl_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output cnt_t             rd_cnt,
  input  logic             we,
  input  logic             init,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             taken
);
  cnt_t mem [2**IDX_W];
  function automatic cnt_t sat(input cnt_t c, input logic t);
    return t ? (c == ST ? ST : cnt_t'(c + 2'd1)) : (c == SNT ? SNT : cnt_t'(c - 2'd1));
  endfunction
  assign rd_cnt = mem[rd_idx];
  always_ff @(posedge clk)
    if (we) mem[wr_idx] <= init ? WNT : sat(mem[wr_idx], taken);
endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: BHT-based branch prediction, misprediction redirect and branch statistics
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_predict_ctrl_if.slave bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     branch_cnt,
  output logic [CNT_W-1:0]     mispred_cnt
);
  state_t           state, state_nx;
  logic [IDX_W-1:0] init_idx;
  cnt_t             rd_cnt;
  logic             ex_act, jmp, mis_t, mis_n, ex_redir, id_redir, upd;
  bht_table #(.IDX_W(IDX_W)) u_bht (
    .clk    (clk),
    .rd_idx (IDX_W'(pc_word(bus.id_pc))),
    .rd_cnt (rd_cnt),
    .we     (busy | upd),
    .init   (busy),
    .wr_idx (busy ? init_idx : IDX_W'(pc_word(bus.ex_pc))),
    .taken  (bus.ex_taken)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state       <= INIT;
      init_idx    <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      state    <= state_nx;
      init_idx <= busy ? init_idx + IDX_W'(1) : init_idx;
      if (upd) begin
        branch_cnt  <= branch_cnt + CNT_W'(branch_cnt != '1);
        mispred_cnt <= mispred_cnt + CNT_W'((bus.ex_taken ^ bus.ex_pred_taken) & (mispred_cnt != '1));
      end
    end
  always_comb begin
    state_nx = (state == INIT && &init_idx) ? RUN : state;
  end
  assign busy              = state == INIT;
  assign bus.id_pred_taken = rd_cnt[1] & bus.id_valid & bus.id_is_branch & ~busy;
  assign ex_act            = bus.ex_valid & ~bus.stall;
  assign jmp               = ex_act & bus.ex_is_jump;
  assign mis_t             = ex_act & bus.ex_is_branch & ~bus.ex_is_jump & bus.ex_taken & ~bus.ex_pred_taken;
  assign mis_n             = ex_act & bus.ex_is_branch & ~bus.ex_is_jump & ~bus.ex_taken & bus.ex_pred_taken;
  assign ex_redir          = jmp | mis_t | mis_n;
  assign id_redir          = bus.id_pred_taken & ~bus.stall;
  assign upd               = ex_act & bus.ex_is_branch & ~bus.ex_is_jump & ~busy;
  assign bus.redirect      = ex_redir | id_redir;
  assign bus.redirect_pc   = (jmp | mis_t) ? bus.ex_target :
                             mis_n         ? bus.ex_pc + 32'd4 :
                             id_redir      ? bus.id_target : 32'd0;
  assign bus.flush_if      = ex_redir | id_redir;
  assign bus.flush_id      = ex_redir;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed and random checks of branch_predict_ctrl against a behavioural model
module tb_branch_predict_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [31:0] branch_cnt, mispred_cnt;
  int          checks = 0;
  int          errors = 0;
  int          tbl [64];
  int          init_left;
  int unsigned m_bcnt, m_mcnt;
  always #5 clk = ~clk;
  branch_predict_ctrl_if bus ();
  branch_predict_ctrl #(.IDX_W(6), .CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clear_in();
    bus.stall = 0; bus.id_valid = 0; bus.id_is_branch = 0; bus.id_pc = 0; bus.id_target = 0;
    bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_is_jump = 0; bus.ex_taken = 0;
    bus.ex_pred_taken = 0; bus.ex_pc = 0; bus.ex_target = 0;
  endtask
  task automatic set_id(input logic [31:0] pc, input logic [31:0] tgt);
    bus.id_valid = 1; bus.id_is_branch = 1; bus.id_pc = pc; bus.id_target = tgt;
  endtask
  task automatic set_ex(input logic br, input logic jp, input logic tk, input logic pt,
                        input logic [31:0] pc, input logic [31:0] tgt);
    bus.ex_valid = 1; bus.ex_is_branch = br; bus.ex_is_jump = jp; bus.ex_taken = tk;
    bus.ex_pred_taken = pt; bus.ex_pc = pc; bus.ex_target = tgt;
  endtask
  function automatic logic [31:0] rnd_pc();
    return (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 8);
  endfunction
  task automatic rand_in();
    bus.stall = ($urandom_range(0, 4) == 0);
    bus.id_valid = 1'($urandom_range(0, 1)); bus.id_is_branch = 1'($urandom_range(0, 1));
    bus.id_pc = rnd_pc(); bus.id_target = $urandom & 32'hFFFF_FFFC;
    bus.ex_valid = 1'($urandom_range(0, 1)); bus.ex_is_branch = 1'($urandom_range(0, 1));
    bus.ex_is_jump = ($urandom_range(0, 3) == 0); bus.ex_taken = 1'($urandom_range(0, 1));
    bus.ex_pred_taken = 1'($urandom_range(0, 1)); bus.ex_pc = rnd_pc();
    bus.ex_target = $urandom & 32'hFFFF_FFFC;
  endtask
  task automatic step();
    logic        e_pred, e_red, e_fid;
    logic [31:0] e_pc;
    #1;
    e_pred = bus.id_valid && bus.id_is_branch && init_left == 0 && tbl[(bus.id_pc >> 2) % 64] >= 2;
    e_red = 0; e_fid = 0; e_pc = 0;
    if (bus.ex_valid && !bus.stall &&
        (bus.ex_is_jump || (bus.ex_is_branch && bus.ex_taken != bus.ex_pred_taken))) begin
      e_red = 1; e_fid = 1;
      e_pc = (bus.ex_is_jump || bus.ex_taken) ? bus.ex_target : bus.ex_pc + 32'd4;
    end else if (e_pred && !bus.stall) begin
      e_red = 1; e_pc = bus.id_target;
    end
    chk("busy", 32'(busy), 32'(init_left > 0));
    chk("id_pred_taken", 32'(bus.id_pred_taken), 32'(e_pred));
    chk("redirect", 32'(bus.redirect), 32'(e_red));
    chk("redirect_pc", bus.redirect_pc, e_pc);
    chk("flush_if", 32'(bus.flush_if), 32'(e_red));
    chk("flush_id", 32'(bus.flush_id), 32'(e_fid));
    chk("branch_cnt", branch_cnt, m_bcnt);
    chk("mispred_cnt", mispred_cnt, m_mcnt);
    @(posedge clk);
    if (!rst_n) begin
      init_left = 64; m_bcnt = 0; m_mcnt = 0;
      foreach (tbl[i]) tbl[i] = 1;
    end else if (init_left > 0) begin
      init_left--;
    end else if (bus.ex_valid && bus.ex_is_branch && !bus.ex_is_jump && !bus.stall) begin
      int k;
      k = (bus.ex_pc >> 2) % 64;
      tbl[k] = bus.ex_taken ? (tbl[k] < 3 ? tbl[k] + 1 : 3) : (tbl[k] > 0 ? tbl[k] - 1 : 0);
      if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
      if (bus.ex_taken != bus.ex_pred_taken && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
    end
    @(negedge clk);
  endtask
  initial begin
    clear_in();
    rst_n = 0;
    init_left = 64; m_bcnt = 0; m_mcnt = 0;
    foreach (tbl[i]) tbl[i] = 1;
    repeat (2) @(negedge clk);
    step(); step();
    rst_n = 1;
    repeat (64) step();
    chk("busy_after_init", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      set_id($urandom & 32'hFFFF_FFFC, 32'h80);
      step();
    end
    clear_in();
    set_ex(1, 0, 1, 0, 32'h100, 32'h80); step();
    set_ex(1, 0, 1, 1, 32'h100, 32'h80); step();
    clear_in();
    set_id(32'h100, 32'h80); step();
    chk("trained_pred", 32'(bus.id_pred_taken), 32'd1);
    clear_in();
    set_ex(1, 0, 0, 1, 32'h200, 32'h300); step();
    clear_in();
    set_id(32'h100, 32'h80);
    set_ex(1, 1, 0, 0, 32'h100, 32'h400); step();
    clear_in();
    set_id(32'h100, 32'h80); step();
    clear_in();
    bus.stall = 1;
    set_ex(1, 0, 1, 0, 32'h104, 32'h500);
    repeat (3) step();
    bus.stall = 0; step();
    clear_in();
    set_ex(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h10); step();
    clear_in();
    for (int i = 0; i < 400; i++) begin
      rand_in();
      step();
    end
    clear_in();
    rst_n = 0; step();
    rst_n = 1;
    repeat (30) step();
    rst_n = 0; step();
    rst_n = 1;
    for (int i = 0; i < 70; i++) begin
      rand_in();
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
